// File: rtl/vgachargen_map_sched.sv
// Access scheduler for the char/colour map ports of the VGA text-mode core.
// Shares each map's single port between the host bus and a bulk engine that
// executes screen-fill and scroll-up-one-row commands.
module vgachargen_map_sched #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int HOST_BURST = 4,
    localparam int N         = COLS * ROWS,
    localparam int ADDR_W    = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic              req_sel_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [7:0]        req_wdata_i,
    output logic              rsp_valid_o,
    output logic [7:0]        rsp_rdata_o,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_op_i,
    input  logic [7:0]        cmd_char_i,
    input  logic [7:0]        cmd_color_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ch_map_addr_o,
    output logic [7:0]        ch_map_data_o,
    output logic              ch_map_wen_o,
    input  logic [7:0]        ch_map_data_i,
    output logic [ADDR_W-1:0] col_map_addr_o,
    output logic [7:0]        col_map_data_o,
    output logic              col_map_wen_o,
    input  logic [7:0]        col_map_data_i
);

    localparam int BW = $clog2(HOST_BURST + 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] SCR_LAST = ADDR_W'(N - COLS - 1);
    localparam logic [ADDR_W-1:0] SCR_FILL = ADDR_W'(N - COLS);

    typedef enum logic [1:0] {IDLE, FILL, SCR_RD, SCR_WR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [7:0]        fchar, fcol, cap_ch, cap_col, wr_ch, wr_col;
    logic [BW-1:0]     burst_cnt;
    logic              rd_pend, rsp_sel, rsp_valid_q, done_q;
    logic              host_gnt, eng_gnt;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign req_ready_o = rst_ni & ((state == IDLE) | (burst_cnt < BW'(HOST_BURST)));
    assign host_gnt    = req_valid_i & req_ready_o;
    assign eng_gnt     = (state != IDLE) & ~host_gnt;

    // An SCR_WR slot directly after its SCR_RD sees the read data on the map
    // inputs before the capture edge, so it forwards data_i instead of cap_*.
    assign wr_ch  = rd_pend ? ch_map_data_i  : cap_ch;
    assign wr_col = rd_pend ? col_map_data_i : cap_col;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_valid_q ? (rsp_sel ? col_map_data_i : ch_map_data_i) : 8'h00;

    // Next-state, pointer update and map port drive for the cycle's owner.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        ch_map_addr_o  = '0;
        ch_map_data_o  = '0;
        ch_map_wen_o   = 1'b0;
        col_map_addr_o = '0;
        col_map_data_o = '0;
        col_map_wen_o  = 1'b0;
        if (host_gnt) begin
            ch_map_addr_o  = req_addr_i;
            col_map_addr_o = req_addr_i;
            if (req_sel_i) begin
                col_map_wen_o  = req_we_i;
                col_map_data_o = req_wdata_i;
            end else begin
                ch_map_wen_o  = req_we_i;
                ch_map_data_o = req_wdata_i;
            end
        end else if (eng_gnt) begin
            case (state)
                FILL: begin
                    ch_map_addr_o  = ptr;
                    col_map_addr_o = ptr;
                    ch_map_data_o  = fchar;
                    col_map_data_o = fcol;
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                    if (ptr == LAST_A) state_nxt = IDLE;
                    else               ptr_nxt   = ptr + 1'b1;
                end
                SCR_RD: begin
                    ch_map_addr_o  = ptr + COLS_A;
                    col_map_addr_o = ptr + COLS_A;
                    state_nxt      = SCR_WR;
                end
                SCR_WR: begin
                    ch_map_addr_o  = ptr;
                    col_map_addr_o = ptr;
                    ch_map_data_o  = wr_ch;
                    col_map_data_o = wr_col;
                    ch_map_wen_o   = 1'b1;
                    col_map_wen_o  = 1'b1;
                    if (ptr == SCR_LAST) begin
                        ptr_nxt   = SCR_FILL;
                        state_nxt = FILL;
                    end else begin
                        ptr_nxt   = ptr + 1'b1;
                        state_nxt = SCR_RD;
                    end
                end
                default: ;
            endcase
        end
        if ((state == IDLE) && cmd_valid_i) begin
            state_nxt = cmd_op_i ? SCR_RD : FILL;
            ptr_nxt   = '0;
        end
    end

    // State, pointer, burst counter, capture, response and done registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            ptr         <= '0;
            burst_cnt   <= '0;
            fchar       <= '0;
            fcol        <= '0;
            cap_ch      <= '0;
            cap_col     <= '0;
            rd_pend     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sel     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if ((state == IDLE) || eng_gnt) burst_cnt <= '0;
            else if (host_gnt)              burst_cnt <= burst_cnt + 1'b1;
            if ((state == IDLE) && cmd_valid_i) begin
                fchar <= cmd_char_i;
                fcol  <= cmd_color_i;
            end
            rd_pend <= eng_gnt && (state == SCR_RD);
            if (rd_pend) begin
                cap_ch  <= ch_map_data_i;
                cap_col <= col_map_data_i;
            end
            rsp_valid_q <= host_gnt & ~req_we_i;
            if (host_gnt) rsp_sel <= req_sel_i;
            done_q <= eng_gnt && (state == FILL) && (ptr == LAST_A);
        end
    end

endmodule

// File: doc/vgachargen_map_sched.md
# vgachargen_map_sched

Access scheduler for the character-map and colour-map memories of the VGA text-mode generator. It shares the single write/read port of each map between a host requester and a built-in bulk engine. The host is the bus side. The bulk engine executes screen-fill and scroll-up-one-row commands. The block sits between the bus slave and the `ch_map_*`/`col_map_*` ports of the text-mode core.

## Interface
Parameters:
- `COLS`, default 80: characters per row.
- `ROWS`, default 30: rows per screen. Derived: `N = COLS*ROWS`, `ADDR_W = $clog2(N)` (12 at defaults).
- `HOST_BURST`, default 4: maximum consecutive host grants while the engine has work pending.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: host access request.
- `req_ready_o` out 1: host request granted this cycle.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_sel_i` in 1: 0 = char map, 1 = colour map.
- `req_addr_i` in ADDR_W: cell address.
- `req_wdata_i` in 8: write data.
- `rsp_valid_o` out 1: host read data valid.
- `rsp_rdata_o` out 8: host read data.
- `cmd_valid_i` in 1: engine command request.
- `cmd_ready_o` out 1: engine can accept a command.
- `cmd_op_i` in 1: 0 = FILL, 1 = SCROLL.
- `cmd_char_i` in 8: fill character.
- `cmd_color_i` in 8: fill colour.
- `busy_o` out 1: engine active.
- `done_o` out 1: one-cycle pulse when a command completes.
- `ch_map_addr_o` out ADDR_W, `ch_map_data_o` out 8, `ch_map_wen_o` out 1: char-map port.
- `ch_map_data_i` in 8: char-map read data.
- `col_map_addr_o` out ADDR_W, `col_map_data_o` out 8, `col_map_wen_o` out 1: colour-map port.
- `col_map_data_i` in 8: colour-map read data.

## Operation
- **Engine FSM states:** IDLE, FILL, SCR_RD, SCR_WR. Registers:
  - `ptr` (ADDR_W).
  - Latched `fchar`/`fcol`.
  - Capture registers `cap_ch`/`cap_col`.
  - `burst_cnt` (`$clog2(HOST_BURST+1)` bits).
- **Command acceptance:**
  - `cmd_ready_o = (state==IDLE)`.
  - On `cmd_valid_i & cmd_ready_o`: latch `fchar`/`fcol`.
  - FILL: go to FILL with `ptr=0`.
  - SCROLL: go to SCR_RD with `ptr=0`.
- **Arbitration (one owner per cycle):**
  - `req_ready_o = rst_ni & (state==IDLE | burst_cnt<HOST_BURST)`; it does not depend on `req_valid_i`.
  - `host_gnt = req_valid_i & req_ready_o`.
  - `eng_gnt = (state!=IDLE) & ~host_gnt`.
- **`burst_cnt`:**
  - Increments on `host_gnt` while `state!=IDLE`.
  - Clears on `eng_gnt` and whenever state is IDLE.
  - The engine therefore gets at least one slot in every `HOST_BURST+1` cycles.
- **Port drive on host_gnt:**
  - Both map addresses = `req_addr_i`.
  - Selected map gets `wen = req_we_i` and `data = req_wdata_i`; the other map has `wen = 0`.
- **Engine actions, only on eng_gnt; otherwise state and `ptr` hold:**
  - **FILL:** write `ptr` in both maps with `fchar`/`fcol`. If `ptr==N-1`, go to IDLE; else `ptr++`.
  - **SCR_RD:** drive address `ptr+COLS` to both maps, wen 0, then go to SCR_WR. In the following cycle (unconditionally, whoever owns it) capture `ch_map_data_i`/`col_map_data_i` into `cap_ch`/`cap_col`.
  - **SCR_WR:** write `ptr` in both maps with `cap_ch`/`cap_col`.
    - If `ptr==N-COLS-1`: `ptr=N-COLS`, go to FILL (which blanks the last row).
    - Else: `ptr++`, go to SCR_RD.
- **Idle port drive:** with no grant, all wen = 0, addresses and data = 0.
- **Host reads:** `rsp_valid_o` = 1 in the cycle after a granted read. `rsp_rdata_o` = data_i of the map chosen by the registered `req_sel_i`.
- **`busy_o`** = `(state!=IDLE)`, registered state.
- **`done_o`** pulses 1 cycle, the cycle after the FILL write at `N-1` (registered).
- **Host/engine ordering:** host writes to cells the engine has not yet written are overwritten by the engine. This is defined behaviour; software waits on `busy_o`.

## Timing
- **Reset values:**
  - State IDLE; `ptr`, `burst_cnt`, `cap_*`, `fchar`, `fcol` = 0.
  - `busy_o`, `done_o`, `rsp_valid_o` = 0; `rsp_rdata_o` = 0.
  - All wen = 0; `req_ready_o` = 0 while `rst_ni` is low.
  - `cmd_ready_o` = 1 after release.
- **Memory port outputs are combinational** from state/grant. Map read latency is 1 cycle.
- **Host latency:** write takes effect at the grant cycle edge; read data returns at grant+1.
- **Uncontended durations (from the accept edge to the `done_o` cycle):**
  - FILL: N+1 = 2401 cycles.
  - SCROLL: 2·(N−COLS) + COLS + 1 = 4721 cycles.
- **Contended stretch:** each host grant during an operation adds exactly 1 cycle.
- **Simultaneous host request and command accept in IDLE:** the host is granted, and the engine starts next cycle.
- **Reset mid-operation:** aborts immediately; maps are left partially updated, no `done_o`.
- **Address arithmetic:** `ptr+COLS` never exceeds N−1 in SCR_RD; no wrap-around.

## Test plan
- **Fill:** FILL with char 0x41, colour 0x1F, no host traffic. `done_o` pulses at cycle 2401. All 2400 cells of both maps read 0x41/0x1F. No wen once idle.
- **Scroll:** preload char[a]=a[7:0] and col[a]=~a[7:0], then SCROLL with fill 0x20/0x07.
  - For a<2320: char[a]=(a+80)[7:0].
  - Cells 2320..2399 = 0x20/0x07.
  - `done_o` at cycle 4721.
- **Host saturation:** `req_valid_i` held 1 during a FILL with HOST_BURST=4.
  - `req_ready_o` pattern is 1,1,1,1,0 repeating.
  - Engine progresses one cell per 5 cycles.
  - `done_o` at 5·2400+1 cycles.
- **Host read:** host reads colour map at address 100 holding 0x5A. `rsp_valid_o`=1 with 0x5A exactly 1 cycle after grant. Char-map wen never asserted.
- **Interrupted scroll:** a host read is granted in the cycle right after an SCR_RD grant. The captured data is still correct and the result matches the scroll test.
- **Reset mid-fill:** drop `rst_ni` at ptr≈1000.
  - Immediately: outputs are at their reset values and `busy_o`=0.
  - After release: no `done_o`, and a new FILL command is accepted and completes.
